// File: rtl/vga_pkg.sv
// Shared VGA timing constants and framebuffer geometry for the 160x120 scan-out path.
package vga_pkg;

  localparam int H_VIS      = 640;
  localparam int H_FP       = 16;
  localparam int H_SYNC     = 96;
  localparam int H_BP       = 48;
  localparam int H_TOTAL    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_VIS      = 480;
  localparam int V_FP       = 10;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 33;
  localparam int V_TOTAL    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FB_W       = 160;
  localparam int FB_H       = 120;
  localparam int ADDR_W     = 15;
  localparam int SCALE_LOG2 = 2;
  localparam int CNT_W      = 10;
  localparam int RGB_W      = 3;
  localparam int DAC_W      = 10;

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel-enable divider and h/v raster counters with stage-0 visibility and sync flags.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int H_VIS  = vga_pkg::H_VIS,
  parameter int H_FP   = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP   = vga_pkg::H_BP,
  parameter int V_VIS  = vga_pkg::V_VIS,
  parameter int V_FP   = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP   = vga_pkg::V_BP
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pix_en,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             vld_p0,
  output logic             hs_p0,
  output logic             vs_p0,
  output logic             frame_start
);

  localparam int HT       = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT       = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_FIRST = H_VIS + H_FP;
  localparam int HS_LAST  = H_VIS + H_FP + H_SYNC - 1;
  localparam int VS_FIRST = V_VIS + V_FP;
  localparam int VS_LAST  = V_VIS + V_FP + V_SYNC - 1;

  logic             pix_en_q, pix_en_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             fs_q, fs_d;

  always_comb begin
    pix_en_d = ~pix_en_q;
    h_d      = h_q;
    v_d      = v_q;
    fs_d     = 1'b0;
    if (pix_en_q) begin
      if (h_q == CNT_W'(HT - 1)) begin
        h_d = '0;
        if (v_q == CNT_W'(VT - 1)) begin
          v_d  = '0;
          fs_d = 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_en_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      fs_q     <= 1'b0;
    end else begin
      pix_en_q <= pix_en_d;
      h_q      <= h_d;
      v_q      <= v_d;
      fs_q     <= fs_d;
    end
  end

  // Stage 0: raster position decoded straight from the counters
  assign vld_p0 = (h_q < CNT_W'(H_VIS)) && (v_q < CNT_W'(V_VIS));
  assign hs_p0  = !((h_q >= CNT_W'(HS_FIRST)) && (h_q <= CNT_W'(HS_LAST)));
  assign vs_p0  = !((v_q >= CNT_W'(VS_FIRST)) && (v_q <= CNT_W'(VS_LAST)));

  assign pix_en      = pix_en_q;
  assign h           = h_q;
  assign v           = v_q;
  assign frame_start = fs_q;

endmodule

// File: rtl/vga_fb_scanout.sv
// 640x480@60 scan-out of a 160x120 3-bit framebuffer, each word replicated 4x4 on screen.
module vga_fb_scanout
  import vga_pkg::*;
#(
  parameter int H_VIS  = vga_pkg::H_VIS,
  parameter int H_FP   = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP   = vga_pkg::H_BP,
  parameter int V_VIS  = vga_pkg::V_VIS,
  parameter int V_FP   = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP   = vga_pkg::V_BP
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [RGB_W-1:0]  rd_data,
  output logic [DAC_W-1:0]  VGA_R,
  output logic [DAC_W-1:0]  VGA_G,
  output logic [DAC_W-1:0]  VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK,
  output logic              VGA_SYNC,
  output logic              VGA_CLK,
  output logic              frame_start
);

  function automatic logic [DAC_W-1:0] replicate(input logic b);
    return {DAC_W{b}};
  endfunction

  logic             pix_en;
  logic [CNT_W-1:0] h, v;
  logic             vld_p0, hs_p0, vs_p0;

  vga_timing_counter #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .h          (h),
    .v          (v),
    .vld_p0     (vld_p0),
    .hs_p0      (hs_p0),
    .vs_p0      (vs_p0),
    .frame_start(frame_start)
  );

  logic [ADDR_W-1:0] x_p0, y_p0, addr_p0;

  // Row stride of 160 words as 128 + 32 to keep it to shifts and one add
  always_comb begin
    y_p0    = ADDR_W'(v >> SCALE_LOG2);
    x_p0    = ADDR_W'(h >> SCALE_LOG2);
    addr_p0 = '0;
    if (vld_p0) begin
      addr_p0 = (y_p0 << 7) + (y_p0 << 5) + x_p0;
    end
  end

  assign rd_addr = addr_p0;

  logic [DAC_W-1:0] r_p1_q, r_p1_d;
  logic [DAC_W-1:0] g_p1_q, g_p1_d;
  logic [DAC_W-1:0] b_p1_q, b_p1_d;
  logic             hs_p1_q, hs_p1_d;
  logic             vs_p1_q, vs_p1_d;
  logic             vld_p1_q, vld_p1_d;

  // Stage 1: one pixel behind the counters; rd_data is only looked at for visible pixels
  always_comb begin
    r_p1_d   = r_p1_q;
    g_p1_d   = g_p1_q;
    b_p1_d   = b_p1_q;
    hs_p1_d  = hs_p1_q;
    vs_p1_d  = vs_p1_q;
    vld_p1_d = vld_p1_q;
    if (pix_en) begin
      hs_p1_d  = hs_p0;
      vs_p1_d  = vs_p0;
      vld_p1_d = vld_p0;
      r_p1_d   = '0;
      g_p1_d   = '0;
      b_p1_d   = '0;
      if (vld_p0) begin
        r_p1_d = replicate(rd_data[2]);
        g_p1_d = replicate(rd_data[1]);
        b_p1_d = replicate(rd_data[0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p1_q   <= '0;
      g_p1_q   <= '0;
      b_p1_q   <= '0;
      hs_p1_q  <= 1'b1;
      vs_p1_q  <= 1'b1;
      vld_p1_q <= 1'b0;
    end else begin
      r_p1_q   <= r_p1_d;
      g_p1_q   <= g_p1_d;
      b_p1_q   <= b_p1_d;
      hs_p1_q  <= hs_p1_d;
      vs_p1_q  <= vs_p1_d;
      vld_p1_q <= vld_p1_d;
    end
  end

  assign VGA_R     = r_p1_q;
  assign VGA_G     = g_p1_q;
  assign VGA_B     = b_p1_q;
  assign VGA_HS    = hs_p1_q;
  assign VGA_VS    = vs_p1_q;
  assign VGA_BLANK = vld_p1_q;
  assign VGA_SYNC  = 1'b0;
  assign VGA_CLK   = pix_en;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout on a shrunken raster so several frames fit in a short run.
module tb_vga_fb_scanout;

  localparam int HV = 64, HFP = 4, HSW = 8, HBP = 4;
  localparam int VV = 32, VFP = 2, VSW = 2, VBP = 4;
  localparam int HT = HV + HFP + HSW + HBP;
  localparam int VT = VV + VFP + VSW + VBP;
  localparam int T  = HT * VT;
  localparam int FRAME_CLKS = 2 * T;
  localparam int MEM_WORDS  = 19200;

  logic        clk;
  logic        reset;
  logic [14:0] rd_addr;
  logic [2:0]  rd_data;
  logic [9:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK, frame_start;

  vga_fb_scanout #(
    .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B),
    .VGA_HS     (VGA_HS),
    .VGA_VS     (VGA_VS),
    .VGA_BLANK  (VGA_BLANK),
    .VGA_SYNC   (VGA_SYNC),
    .VGA_CLK    (VGA_CLK),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] mem [0:MEM_WORDS-1];
  logic       poison;

  function automatic logic [2:0] ram_word(input int a);
    if (a < 0 || a >= MEM_WORDS) return 3'b000;
    if (poison && a == 0) return 3'b111;
    return mem[a];
  endfunction

  always @(posedge clk) rd_data <= ram_word(int'(rd_addr));

  int n;
  always @(posedge clk) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h (clk %0d since reset)", tag, got, exp, n);
    end
  endtask

  function automatic int exp_addr(input int p);
    int h, v;
    h = p % HT;
    v = p / HT;
    if (h < HV && v < VV) return (v / 4) * 160 + (h / 4);
    return 0;
  endfunction

  logic directed;
  int   hs_fall1, hs_fall2, hs_ticks, vs_fall, vs_rise, fs_first;
  logic prev_hs, prev_vs;

  task automatic clear_meas();
    hs_fall1 = -1; hs_fall2 = -1; hs_ticks = 0;
    vs_fall  = -1; vs_rise  = -1; fs_first = -1;
    prev_hs  = 1'b1; prev_vs = 1'b1;
  endtask

  // Output at clk n shows pixel (n-2)/2; the counters themselves sit at pixel n/2.
  task automatic check_cycle();
    int p, q, h, v;
    logic vis, ehs, evs;
    logic [2:0] w;
    p = (n / 2) % T;
    check_eq("rd_addr", 32'(rd_addr), 32'(exp_addr(p)));
    if (n < 2) begin
      vis = 1'b0; ehs = 1'b1; evs = 1'b1; w = 3'b000;
    end else begin
      q   = ((n - 2) / 2) % T;
      h   = q % HT;
      v   = q / HT;
      vis = (h < HV) && (v < VV);
      ehs = !(h >= HV + HFP && h < HV + HFP + HSW);
      evs = !(v >= VV + VFP && v < VV + VFP + VSW);
      w   = vis ? ram_word(exp_addr(q)) : 3'b000;
    end
    check_eq("vga_r", 32'(VGA_R), 32'({10{w[2]}}));
    check_eq("vga_g", 32'(VGA_G), 32'({10{w[1]}}));
    check_eq("vga_b", 32'(VGA_B), 32'({10{w[0]}}));
    check_eq("vga_hs", 32'(VGA_HS), 32'(ehs));
    check_eq("vga_vs", 32'(VGA_VS), 32'(evs));
    check_eq("vga_blank", 32'(VGA_BLANK), 32'(vis));
    check_eq("vga_sync", 32'(VGA_SYNC), 32'(0));
    check_eq("vga_clk", 32'(VGA_CLK), 32'(n % 2));
    check_eq("frame_start", 32'(frame_start), 32'(n > 0 && n % FRAME_CLKS == 0));

    if (directed) begin
      if (n == 8)                               check_eq("addr_4_0", 32'(rd_addr), 32'(1));
      if (n == 2 * 4 * HT)                      check_eq("addr_0_4", 32'(rd_addr), 32'(160));
      if (n == 2 * ((VV - 1) * HT + HV - 1))    check_eq("addr_last", 32'(rd_addr), 32'(7 * 160 + 15));
      if (n == 2 * (10 * HT + HV + 10))         check_eq("addr_blank", 32'(rd_addr), 32'(0));
      if (n == 2 * (5 * HT + 5) + 2) begin
        check_eq("pix55_r", 32'(VGA_R), 32'h3ff);
        check_eq("pix55_g", 32'(VGA_G), 32'h000);
        check_eq("pix55_b", 32'(VGA_B), 32'h3ff);
        check_eq("pix55_blank", 32'(VGA_BLANK), 32'(1));
      end
    end

    if (reset) begin
      clear_meas();
    end else begin
      if (prev_hs && !VGA_HS) begin
        if (hs_fall1 < 0)      hs_fall1 = n;
        else if (hs_fall2 < 0) hs_fall2 = n;
      end
      if (!VGA_HS && n >= 2 && n < 2 * HT + 2 && n % 2 == 0) hs_ticks++;
      if (prev_vs && !VGA_VS && vs_fall < 0) vs_fall = n;
      if (!prev_vs && VGA_VS && vs_rise < 0) vs_rise = n;
      if (frame_start && fs_first < 0) fs_first = n;
      prev_hs = VGA_HS;
      prev_vs = VGA_VS;
    end
  endtask

  initial begin
    reset    = 1'b1;
    poison   = 1'b0;
    directed = 1'b0;
    clear_meas();
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 3'(i);
    mem[161] = 3'b101;

    repeat (3) begin @(negedge clk); check_cycle(); end
    reset    = 1'b0;
    directed = 1'b1;
    repeat (FRAME_CLKS + 200) begin @(negedge clk); check_cycle(); end
    directed = 1'b0;

    check_eq("hs_fall_pos", 32'(hs_fall1), 32'(2 * (HV + HFP) + 2));
    check_eq("hs_period", 32'(hs_fall2 - hs_fall1), 32'(2 * HT));
    check_eq("hs_ticks_line0", 32'(hs_ticks), 32'(HSW));
    check_eq("vs_fall_pos", 32'(vs_fall), 32'(2 * (VV + VFP) * HT + 2));
    check_eq("vs_low_clks", 32'(vs_rise - vs_fall), 32'(2 * VSW * HT));
    check_eq("first_frame_start", 32'(fs_first), 32'(FRAME_CLKS));

    // Random framebuffer contents; address 0 reads as 7 to poison the blanking reads
    reset  = 1'b1;
    poison = 1'b1;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 3'($urandom_range(0, 7));
    mem[161] = 3'b101;
    repeat (2) begin @(negedge clk); check_cycle(); end
    reset = 1'b0;
    repeat (FRAME_CLKS + 2 * (20 * HT + 30)) begin @(negedge clk); check_cycle(); end
    check_eq("pre_reset_n", 32'(n % FRAME_CLKS), 32'(2 * (20 * HT + 30)));

    reset = 1'b1;
    @(negedge clk); check_cycle();
    check_eq("midrst_hs", 32'(VGA_HS), 32'(1));
    check_eq("midrst_blank", 32'(VGA_BLANK), 32'(0));
    check_eq("midrst_addr", 32'(rd_addr), 32'(0));
    reset = 1'b0;
    repeat (FRAME_CLKS + 20) begin @(negedge clk); check_cycle(); end
    check_eq("frame_start_after_rst", 32'(fs_first), 32'(FRAME_CLKS));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
